// File: rtl/lcd_spi_pkg.sv
// Shared constants, decoder state encoding and helpers for the LCD SPI sink.
package lcd_spi_pkg;

   localparam int unsigned DEF_WIDTH  = 160;
   localparam int unsigned DEF_HEIGHT = 128;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CASET_P  = 3'd1,
      ST_RASET_P  = 3'd2,
      ST_RAMWR_HI = 3'd3,
      ST_RAMWR_LO = 3'd4
   } dec_state_t;

   function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Serial front end: synchronizes the LCD SPI pins into clk and assembles
// MSB-first bytes on scl rising edges while cs is low.
module spi_byte_rx (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda,
   input  logic       cs,
   input  logic       rs,
   output logic       byte_valid,
   output logic [7:0] data_byte,
   output logic       rs_bit
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic [1:0] cs_sync;
   logic [1:0] rs_sync;
   logic       scl_d;
   logic [6:0] shift;
   logic [2:0] bit_cnt;
   logic       scl_rise;

   assign scl_rise = scl_sync[1] & ~scl_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync   <= 2'b00;
         sda_sync   <= 2'b00;
         cs_sync    <= 2'b11;
         rs_sync    <= 2'b00;
         scl_d      <= 1'b0;
         shift      <= 7'd0;
         bit_cnt    <= 3'd0;
         byte_valid <= 1'b0;
         data_byte  <= 8'd0;
         rs_bit     <= 1'b0;
      end else begin
         scl_sync   <= {scl_sync[0], scl};
         sda_sync   <= {sda_sync[0], sda};
         cs_sync    <= {cs_sync[0], cs};
         rs_sync    <= {rs_sync[0], rs};
         scl_d      <= scl_sync[1];
         byte_valid <= 1'b0;
         // Deselect drops any partial byte; the next bit is bit 7 again.
         if (cs_sync[1]) begin
            bit_cnt <= 3'd0;
         end else if (scl_rise) begin
            shift   <= {shift[5:0], sda_sync[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               data_byte  <= {shift, sda_sync[1]};
               rs_bit     <= rs_sync[1];
            end
         end
      end
   end

endmodule

// File: rtl/lcd_spi_sink.sv
// LCD controller sink: decodes CASET/RASET/RAMWR from the SPI byte stream and
// emits addressed RGB565 pixels. Define LCD_SPI_SINK_CHECKSUM_EN for frame_sum.
module lcd_spi_sink
   import lcd_spi_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl,
   input  logic        sda,
   input  logic        cs,
   input  logic        rs,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        pix_valid,
   output logic [7:0]  pix_x,
   output logic [6:0]  pix_y,
   output logic [15:0] pix_rgb,
   output logic        frame_done,
   output logic [15:0] frame_sum
);

   localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
   localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

   logic       byte_valid;
   logic       rs_bit;
   logic [7:0] data_byte;

   spi_byte_rx u_rx (
      .clk        (clk),
      .reset      (reset),
      .scl        (scl),
      .sda        (sda),
      .cs         (cs),
      .rs         (rs),
      .byte_valid (byte_valid),
      .data_byte  (data_byte),
      .rs_bit     (rs_bit)
   );

   dec_state_t  state, state_n;
   logic [1:0]  pcnt, pcnt_n;
   logic [7:0]  pstart, pstart_n;
   logic [7:0]  xs, xs_n, xe, xe_n, x_ptr, x_ptr_n;
   logic [6:0]  ys, ys_n, ye, ye_n, y_ptr, y_ptr_n;
   logic [7:0]  hi, hi_n;
   logic        cmd_valid_n, pix_valid_n, frame_done_n;
   logic [7:0]  cmd_byte_n, pix_x_n;
   logic [6:0]  pix_y_n;
   logic [15:0] pix_rgb_n;
   logic [7:0]  lim, pend, end_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         pcnt       <= 2'd0;
         pstart     <= 8'd0;
         xs         <= 8'd0;
         xe         <= X_MAX;
         ys         <= 7'd0;
         ye         <= Y_MAX[6:0];
         x_ptr      <= 8'd0;
         y_ptr      <= 7'd0;
         hi         <= 8'd0;
         cmd_valid  <= 1'b0;
         cmd_byte   <= 8'd0;
         pix_valid  <= 1'b0;
         pix_x      <= 8'd0;
         pix_y      <= 7'd0;
         pix_rgb    <= 16'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         pcnt       <= pcnt_n;
         pstart     <= pstart_n;
         xs         <= xs_n;
         xe         <= xe_n;
         ys         <= ys_n;
         ye         <= ye_n;
         x_ptr      <= x_ptr_n;
         y_ptr      <= y_ptr_n;
         hi         <= hi_n;
         cmd_valid  <= cmd_valid_n;
         cmd_byte   <= cmd_byte_n;
         pix_valid  <= pix_valid_n;
         pix_x      <= pix_x_n;
         pix_y      <= pix_y_n;
         pix_rgb    <= pix_rgb_n;
         frame_done <= frame_done_n;
      end
   end

   always_comb begin
      state_n      = state;
      pcnt_n       = pcnt;
      pstart_n     = pstart;
      xs_n         = xs;
      xe_n         = xe;
      ys_n         = ys;
      ye_n         = ye;
      x_ptr_n      = x_ptr;
      y_ptr_n      = y_ptr;
      hi_n         = hi;
      cmd_valid_n  = 1'b0;
      cmd_byte_n   = cmd_byte;
      pix_valid_n  = 1'b0;
      pix_x_n      = pix_x;
      pix_y_n      = pix_y;
      pix_rgb_n    = pix_rgb;
      frame_done_n = 1'b0;
      lim          = (state == ST_CASET_P) ? X_MAX : Y_MAX;
      pend         = clamp8(data_byte, lim);
      end_val      = (pstart > pend) ? pstart : pend;

      if (byte_valid) begin
         if (!rs_bit) begin
            // Any command aborts the current transaction and dispatches.
            cmd_valid_n = 1'b1;
            cmd_byte_n  = data_byte;
            pcnt_n      = 2'd0;
            case (data_byte)
               CMD_CASET: state_n = ST_CASET_P;
               CMD_RASET: state_n = ST_RASET_P;
               CMD_RAMWR: begin
                  state_n = ST_RAMWR_HI;
                  x_ptr_n = xs;
                  y_ptr_n = ys;
               end
               default:   state_n = ST_IDLE;
            endcase
         end else begin
            case (state)
               ST_CASET_P, ST_RASET_P: begin
                  pcnt_n = pcnt + 2'd1;
                  if (pcnt == 2'd1) pstart_n = pend;
                  if (pcnt == 2'd3) begin
                     state_n = ST_IDLE;
                     if (state == ST_CASET_P) begin
                        xs_n = pstart;
                        xe_n = end_val;
                     end else begin
                        ys_n = pstart[6:0];
                        ye_n = end_val[6:0];
                     end
                  end
               end
               ST_RAMWR_HI: begin
                  hi_n    = data_byte;
                  state_n = ST_RAMWR_LO;
               end
               ST_RAMWR_LO: begin
                  state_n     = ST_RAMWR_HI;
                  pix_valid_n = 1'b1;
                  pix_x_n     = x_ptr;
                  pix_y_n     = y_ptr;
                  pix_rgb_n   = {hi, data_byte};
                  // Raster advance within the window, wrapping at its end.
                  if (x_ptr == xe) begin
                     x_ptr_n = xs;
                     if (y_ptr == ye) begin
                        y_ptr_n      = ys;
                        frame_done_n = 1'b1;
                     end else begin
                        y_ptr_n = y_ptr + 7'd1;
                     end
                  end else begin
                     x_ptr_n = x_ptr + 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LCD_SPI_SINK_CHECKSUM_EN
   logic [15:0] acc;
   logic        ramwr_load;

   assign ramwr_load = byte_valid && !rs_bit && (data_byte == CMD_RAMWR);

   // Frame checksum: running sum, latched together with frame_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= 16'd0;
         frame_sum <= 16'd0;
      end else if (ramwr_load) begin
         acc <= 16'd0;
      end else if (pix_valid_n) begin
         if (frame_done_n) begin
            frame_sum <= acc + pix_rgb_n;
            acc       <= 16'd0;
         end else begin
            acc <= acc + pix_rgb_n;
         end
      end
   end
`else
   assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Self-checking bench for lcd_spi_sink: directed vector table, randomized byte
// stream against a window/pixel-index model, plus abort and reset sequences.
module tb_lcd_spi_sink;

   logic        clk = 1'b0;
   logic        reset, scl, sda, cs, rs;
   logic        cmd_valid, pix_valid, frame_done;
   logic [7:0]  cmd_byte, pix_x;
   logic [6:0]  pix_y;
   logic [15:0] pix_rgb, frame_sum;

   lcd_spi_sink #(.WIDTH(160), .HEIGHT(128)) dut (
      .clk(clk), .reset(reset), .scl(scl), .sda(sda), .cs(cs), .rs(rs),
      .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_done(frame_done), .frame_sum(frame_sum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0, odd_pulse = 0, last_rise = 0;

   typedef struct {
      int          kind;   // 1 = command, 2 = pixel
      logic [7:0]  cmd;
      int          x, y;
      logic [15:0] rgb;
      bit          fd;
      logic [15:0] sum;
      int          lat;
   } ev_t;

   ev_t obs[$];
   ev_t mev;

   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid && pix_valid) odd_pulse++;
         if (frame_done && !pix_valid) odd_pulse++;
         if (cmd_valid) begin
            mev = '{1, cmd_byte, 0, 0, 16'd0, 1'b0, 16'd0, 0};
            obs.push_back(mev);
         end
         if (pix_valid) begin
            mev = '{2, 8'd0, int'(pix_x), int'(pix_y), pix_rgb, frame_done, frame_sum, cyc - last_rise};
            obs.push_back(mev);
         end
      end
   end

   function automatic logic [15:0] exp_sum(input logic [15:0] v);
`ifdef LCD_SPI_SINK_CHECKSUM_EN
      return v;
`else
      return 16'd0 & v;
`endif
   endfunction

   // Reference model: window in plain ints, pixel position from a running index.
   int m_mode, m_xs, m_xe, m_ys, m_ye, m_n, m_hi;
   logic [15:0] m_sum;
   int m_par[$];

   task automatic model_reset();
      m_mode = 0; m_xs = 0; m_xe = 159; m_ys = 0; m_ye = 127; m_n = 0; m_hi = 0;
      m_sum = 16'd0; m_par.delete();
   endtask

   task automatic model_byte(input bit r, input logic [7:0] b, output int ek, output int ex,
                             output int ey, output logic [15:0] ergb, output bit efd,
                             output logic [15:0] esum);
      int lim, s, e, w, h;
      ek = 0; ex = 0; ey = 0; ergb = 16'd0; efd = 1'b0; esum = 16'd0;
      if (!r) begin
         ek = 1;
         m_par.delete();
         if (b == 8'h2A) m_mode = 1;
         else if (b == 8'h2B) m_mode = 2;
         else if (b == 8'h2C) begin m_mode = 3; m_n = 0; m_sum = 16'd0; end
         else m_mode = 0;
      end else if (m_mode == 1 || m_mode == 2) begin
         m_par.push_back(int'(b));
         if (m_par.size() == 4) begin
            lim = (m_mode == 1) ? 159 : 127;
            s = (m_par[1] > lim) ? lim : m_par[1];
            e = (m_par[3] > lim) ? lim : m_par[3];
            if (s > e) e = s;
            if (m_mode == 1) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
            m_par.delete();
            m_mode = 0;
         end
      end else if (m_mode == 3) begin
         m_hi = int'(b);
         m_mode = 4;
      end else if (m_mode == 4) begin
         w = m_xe - m_xs + 1;
         h = m_ye - m_ys + 1;
         ek = 2;
         ex = m_xs + (m_n % w);
         ey = m_ys + ((m_n / w) % h);
         ergb = 16'(m_hi * 256 + int'(b));
         m_sum = m_sum + ergb;
         m_n++;
         efd = ((m_n % (w * h)) == 0);
         if (efd) begin esum = exp_sum(m_sum); m_sum = 16'd0; end
         m_mode = 3;
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input bit r, input logic [7:0] b, input int nb);
      logic [7:0] v;
      v = b;
      for (int i = 0; i < nb; i++) begin
         scl = 1'b0; sda = v[7 - i]; rs = r;
         wclk(4);
         scl = 1'b1; last_rise = cyc;
         wclk(4);
      end
      scl = 1'b0;
      wclk(4);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_ev(input string nm, input int ek, input logic [7:0] ecmd, input int ex,
                           input int ey, input logic [15:0] ergb, input bit efd,
                           input logic [15:0] esum);
      if (ek == 0) begin
         chk({nm, " no_event"}, 32'(obs.size()), 32'd0);
      end else begin
         chk({nm, " event_count"}, 32'(obs.size()), 32'd1);
         if (obs.size() >= 1) begin
            chk({nm, " kind"}, 32'(obs[0].kind), 32'(ek));
            if (ek == 1) begin
               chk({nm, " cmd_byte"}, 32'(obs[0].cmd), 32'(ecmd));
            end else begin
               chk({nm, " pix_x"}, 32'(obs[0].x), 32'(ex));
               chk({nm, " pix_y"}, 32'(obs[0].y), 32'(ey));
               chk({nm, " pix_rgb"}, 32'(obs[0].rgb), 32'(ergb));
               chk({nm, " frame_done"}, 32'(obs[0].fd), 32'(efd));
               chk({nm, " latency"}, 32'(obs[0].lat), 32'd4);
               if (efd) chk({nm, " frame_sum"}, 32'(obs[0].sum), 32'(esum));
            end
         end
      end
      obs.delete();
   endtask

   // Send one byte and check it against the model.
   task automatic xfer(input string nm, input bit r, input logic [7:0] b);
      int ek, ex, ey;
      logic [15:0] ergb, esum;
      bit efd;
      model_byte(r, b, ek, ex, ey, ergb, efd, esum);
      send_bits(r, b, 8);
      check_ev(nm, ek, b, ex, ey, ergb, efd, esum);
   endtask

   typedef struct {
      bit          rs;
      logic [7:0]  d;
      int          ek;
      int          ex, ey;
      logic [15:0] ergb;
      bit          efd;
      logic [15:0] esum;
   } vec_t;

   vec_t tbl[$];

   task automatic add_cmd(input logic [7:0] b);
      tbl.push_back('{1'b0, b, 1, 0, 0, 16'd0, 1'b0, 16'd0});
   endtask
   task automatic add_dat(input logic [7:0] b);
      tbl.push_back('{1'b1, b, 0, 0, 0, 16'd0, 1'b0, 16'd0});
   endtask
   task automatic add_pix(input logic [7:0] b, input int x, input int y, input logic [15:0] rgb,
                          input bit fd, input logic [15:0] sum);
      tbl.push_back('{1'b1, b, 2, x, y, rgb, fd, sum});
   endtask
   task automatic add_win(input logic [7:0] c, input logic [7:0] s, input logic [7:0] e);
      add_cmd(c); add_dat(8'h00); add_dat(s); add_dat(8'h00); add_dat(e);
   endtask

   initial begin
      int ek, ex, ey, sel, rr;
      logic [15:0] ergb, esum;
      bit efd;
      logic [7:0] b;
      int px[6] = '{16, 17, 18, 16, 17, 18};
      int py[6] = '{5, 5, 5, 6, 6, 6};

      reset = 1'b1; scl = 1'b0; sda = 1'b0; cs = 1'b1; rs = 1'b0;
      wclk(4);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
      chk("reset cmd_byte", 32'(cmd_byte), 32'd0);
      chk("reset pix_valid", 32'(pix_valid), 32'd0);
      chk("reset pix_x", 32'(pix_x), 32'd0);
      chk("reset pix_y", 32'(pix_y), 32'd0);
      chk("reset pix_rgb", 32'(pix_rgb), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset frame_sum", 32'(frame_sum), 32'd0);
      wclk(1);
      cs = 1'b0;
      wclk(4);

      // Directed vectors with hand-derived expectations.
      add_cmd(8'h2C); add_dat(8'hF8); add_pix(8'h00, 0, 0, 16'hF800, 1'b0, 16'd0);
      add_win(8'h2A, 8'h10, 8'h12);
      add_win(8'h2B, 8'h05, 8'h06);
      add_cmd(8'h2C);
      for (int k = 1; k <= 6; k++) begin
         add_dat(8'h00);
         add_pix(8'(k), px[k-1], py[k-1], 16'(k), k == 6, exp_sum(16'h0015));
      end
      add_win(8'h2A, 8'hC8, 8'hFF);
      add_cmd(8'h2C); add_dat(8'h12); add_pix(8'h34, 159, 5, 16'h1234, 1'b0, 16'd0);
      add_dat(8'hAB); add_cmd(8'h00); add_dat(8'h12);
      add_win(8'h2B, 8'h06, 8'h03);
      add_cmd(8'h2C); add_dat(8'hBE); add_pix(8'hEF, 159, 6, 16'hBEEF, 1'b1, exp_sum(16'hBEEF));
      add_win(8'h2A, 8'h00, 8'h00);
      add_win(8'h2B, 8'h00, 8'h01);
      add_cmd(8'h2C);
      add_dat(8'hFF); add_pix(8'hFF, 0, 0, 16'hFFFF, 1'b0, 16'd0);
      add_dat(8'h00); add_pix(8'h02, 0, 1, 16'h0002, 1'b1, exp_sum(16'h0001));

      for (int i = 0; i < tbl.size(); i++) begin
         model_byte(tbl[i].rs, tbl[i].d, ek, ex, ey, ergb, efd, esum);
         send_bits(tbl[i].rs, tbl[i].d, 8);
         check_ev($sformatf("vec%0d", i), tbl[i].ek, tbl[i].d, tbl[i].ex, tbl[i].ey,
                  tbl[i].ergb, tbl[i].efd, tbl[i].esum);
      end

      // Randomized byte stream against the model.
      for (int i = 0; i < 300; i++) begin
         rr = int'($urandom_range(0, 99));
         if (rr < 12) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
               0: b = 8'h2A;
               1: b = 8'h2B;
               2, 3: b = 8'h2C;
               default: b = 8'($urandom);
            endcase
            xfer($sformatf("rnd%0d", i), 1'b0, b);
         end else begin
            if ((m_mode == 1 || m_mode == 2) && (m_par.size() % 2 == 1) && ($urandom_range(0, 3) != 0))
               b = m_par.size() == 1 ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 6));
            else
               b = 8'($urandom);
            xfer($sformatf("rnd%0d", i), 1'b1, b);
         end
      end

      // cs abort after 5 bits, then a complete command.
      send_bits(1'b1, 8'hFF, 5);
      cs = 1'b1; wclk(4); cs = 1'b0; wclk(4);
      check_ev("abort partial", 0, 8'h00, 0, 0, 16'd0, 1'b0, 16'd0);
      xfer("abort cmd", 1'b0, 8'h2C);
      send_bits(1'b1, 8'hFF, 3);
      cs = 1'b1; wclk(4); cs = 1'b0; wclk(4);
      xfer("abort hi", 1'b1, 8'h12);
      xfer("abort lo", 1'b1, 8'h34);

      // Reset in the middle of a pixel.
      xfer("rst hi", 1'b1, 8'h56);
      send_bits(1'b1, 8'hFF, 4);
      reset = 1'b1; wclk(3); reset = 1'b0;
      model_reset();
      wclk(4);
      check_ev("rst partial", 0, 8'h00, 0, 0, 16'd0, 1'b0, 16'd0);
      xfer("rst cmd", 1'b0, 8'h2C);
      xfer("rst hi2", 1'b1, 8'h00);
      xfer("rst lo2", 1'b1, 8'h07);

      chk("no_coincident_pulses", 32'(odd_pulse), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_spi_sink.md
LCD_SPI_SINK -- requirements
Module: lcd_spi_sink

Interface
REQ-001 Parameter WIDTH, default 160: panel columns; x coordinates clamp to WIDTH-1.
REQ-002 Parameter HEIGHT, default 128: panel rows; y coordinates clamp to HEIGHT-1.
REQ-003 clk  input  1  system clock; the single clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl  input  1  serial clock from the LCD transmitter, asynchronous to clk.
REQ-006 sda  input  1  serial data, MSB first.
REQ-007 cs  input  1  chip select, active low.
REQ-008 rs  input  1  register select: 0 = command byte, 1 = data byte.
REQ-009 cmd_valid  output  1  one-clk pulse per received command byte.
REQ-010 cmd_byte  output  8  last command byte; held between pulses.
REQ-011 pix_valid  output  1  one-clk pulse per assembled pixel.
REQ-012 pix_x  output  8  column of the current pixel.
REQ-013 pix_y  output  7  row of the current pixel.
REQ-014 pix_rgb  output  16  RGB565 pixel, first byte = bits [15:8].
REQ-015 frame_done  output  1  one-clk pulse, coincident with pix_valid for the window's last pixel.
REQ-016 frame_sum  output  16  per-frame pixel checksum (see Configuration).

Function
REQ-017 scl, sda, cs and rs SHALL each pass through a 2-flop synchronizer; scl rising-edge detect compares sync stage 2 with a third flop.
REQ-018 Bits SHALL be sampled on detected scl rising edges only while synchronized cs is low (SPI mode 0).
REQ-019 Transmitter scl high and low phases SHALL each be at least 3 clk periods; behaviour outside this limit is unspecified.
REQ-020 A byte SHALL complete on its 8th bit; rs is sampled together with the 8th bit.
REQ-021 Synchronized cs going high SHALL discard any partial byte and reset the bit counter; the decoder state is kept.
REQ-022 Decoder states: IDLE, CASET_P, RASET_P, RAMWR_HI, RAMWR_LO.
REQ-023 Every command byte SHALL pulse cmd_valid and update cmd_byte, terminate the current state, and dispatch:
- 0x2A -> CASET_P
- 0x2B -> RASET_P
- 0x2C -> RAMWR_HI, with the pointer loaded to (xs, ys)
- any other -> IDLE
REQ-024 CASET_P/RASET_P SHALL take 4 parameter bytes (start hi, start lo, end hi, end lo):
- only the lo bytes are used, clamped to WIDTH-1 / HEIGHT-1
- the window register updates after the 4th byte
- if start > end, end is set equal to start
- the state then returns to IDLE.
REQ-025 Data bytes in IDLE SHALL be ignored.
REQ-026 RAMWR_HI SHALL latch the high byte and go to RAMWR_LO; RAMWR_LO SHALL emit a pixel and return to RAMWR_HI.
REQ-027 pix_valid SHALL assert exactly 4 clk cycles after the raw scl rising edge carrying the pixel's last bit; pix_x, pix_y and pix_rgb SHALL be valid in that cycle.
REQ-028 Pointer advance after each pixel:
- x == xe: x <- xs, y++
- y == ye and x == xe: pointer wraps to (xs, ys) and frame_done pulses.
REQ-029 cmd_valid and pix_valid SHALL never assert in the same cycle.

Reset
REQ-030 Reset SHALL apply:
- state IDLE, bit counter 0
- all pulses 0, cmd_byte 0, pix_x/pix_y/pix_rgb 0, frame_sum 0
- window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1.
REQ-031 Reset asserted mid-byte or mid-pixel SHALL discard partial data; the first byte after release starts at bit 7.

Configuration
REQ-032 With LCD_SPI_SINK_CHECKSUM_EN defined:
- a 16-bit wrapping sum of pix_rgb accumulates per frame
- frame_sum latches the sum including the last pixel in the frame_done cycle
- the accumulator clears on RAMWR and on frame_done.
REQ-033 Without LCD_SPI_SINK_CHECKSUM_EN, frame_sum SHALL be constant 0 and no accumulator SHALL exist.

Structure
REQ-034 Package lcd_spi_pkg SHALL hold:
- opcode constants CMD_CASET=0x2A, CMD_RASET=0x2B, CMD_RAMWR=0x2C
- the decoder state enum
- default WIDTH and HEIGHT.
REQ-035 Sub-module spi_byte_rx SHALL contain the synchronizers, edge detect, shift register and bit counter, and SHALL emit byte_valid, byte and rs_bit.

Verification
REQ-036 Command 0x2C then data 0xF8,0x00 -> cmd_valid with cmd_byte=0x2C; pix_valid with pix_rgb=0xF800 at (0,0), 4 clk after the last raw scl edge.
REQ-037 CASET 00,10,00,12; RASET 00,05,00,06; RAMWR plus 6 pixels -> pixels at (16,5), (17,5), (18,5), (16,6), (17,6), (18,6); frame_done with the 6th pixel.
REQ-038 cs raised after 5 bits of a byte, then a full byte 0x2C -> only 0x2C is decoded; no spurious byte.
REQ-039 CASET 00,C8,00,FF with WIDTH=160 -> xs=xe=159; the next pixel lands at x=159.
REQ-040 RAMWR high byte, then command 0x00, then data 0x12 -> no pix_valid; cmd_valid for 0x00; the data byte is ignored.
REQ-041 LCD_SPI_SINK_CHECKSUM_EN defined, 1x2 window, pixels 0xFFFF and 0x0002 -> frame_sum=0x0001 at frame_done; macro undefined -> frame_sum=0.
